// File: rtl/islip_pkg.sv
// Shared iSLIP scheduler definitions: arbiter state encoding, pointer-width helper and the
// default port count / grant-timeout constants used by request evaluation and accept stages.
package islip_pkg;

    localparam int unsigned ISLIP_N              = 24;
    localparam int unsigned ISLIP_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } arb_state_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: one-hot grant for the first request bit at or after
// the pointer, wrapping from N-1 back to 0. Shared by the grant and accept arbiters.
module rr_select
    import islip_pkg::*;
#(
    parameter  int unsigned N  = ISLIP_N,
    localparam int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [PW-1:0] i_pointer,
    output logic [N-1:0]  o_grant,
    output logic          o_any
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_mask[i] = (i >= int'(i_pointer));
        end
    end

    assign w_hi = i_request & w_mask;

    // x & -x isolates the lowest set bit; fall back to the unmasked vector to wrap around.
    always_comb begin
        if (|w_hi) begin
            o_grant = w_hi & (-w_hi);
        end else begin
            o_grant = i_request & (-i_request);
        end
    end

    assign o_any = |i_request;

endmodule

// File: rtl/islip_grant_arbiter.sv
// iSLIP grant arbiter for one output port: registered one-hot grant held until accept/reject.
// Optional grant-hold timeout enabled by defining ISLIP_GRANT_TIMEOUT_EN.
module islip_grant_arbiter
    import islip_pkg::*;
#(
    parameter  int unsigned N              = ISLIP_N,
    parameter  int unsigned TIMEOUT_CYCLES = ISLIP_TIMEOUT_CYCLES,
    localparam int unsigned PW             = ptr_width(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_request,
    input  logic          i_req_valid,
    input  logic          i_first_iter,
    input  logic          i_accept,
    input  logic          i_reject,
    output logic          o_ready,
    output logic [N-1:0]  o_grant,
    output logic          o_grant_valid,
    output logic [PW-1:0] o_pointer,
    output logic          o_timeout
);

    if (N < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("islip_grant_arbiter: N must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e    r_state, w_state_d;
    logic [N-1:0]  r_grant, w_grant_d, w_sel;
    logic          r_first, w_first_d;
    logic [PW-1:0] r_pointer, w_pointer_d;
    logic [PW-1:0] w_gidx, w_ptr_adv;
    logic          w_any;
    logic          w_expire;

    rr_select #(
        .N (N)
    ) u_rr_select (
        .i_request (i_request),
        .i_pointer (r_pointer),
        .o_grant   (w_sel),
        .o_any     (w_any)
    );

    // r_grant is one-hot, so OR-ing the indices of set bits yields the granted index.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (r_grant[i]) begin
                w_gidx = w_gidx | PW'(i);
            end
        end
    end

    assign w_ptr_adv = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);

    always_comb begin
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_first_d   = r_first;
        w_pointer_d = r_pointer;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid && w_any) begin
                    w_state_d = StWait;
                    w_grant_d = w_sel;
                    w_first_d = i_first_iter;
                end
            end
            StWait: begin
                if (i_accept) begin
                    w_state_d = StIdle;
                    w_grant_d = '0;
                    if (r_first) begin
                        w_pointer_d = w_ptr_adv;
                    end
                end else if (i_reject || w_expire) begin
                    w_state_d = StIdle;
                    w_grant_d = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_first   <= 1'b0;
            r_pointer <= '0;
        end else begin
            r_state   <= w_state_d;
            r_grant   <= w_grant_d;
            r_first   <= w_first_d;
            r_pointer <= w_pointer_d;
        end
    end

`ifdef ISLIP_GRANT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;

    // Held at zero while idle so every WAIT entry starts counting from zero.
    assign w_expire = (r_state == StWait) && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire && !i_accept && !i_reject;
            if (r_state == StIdle) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_expire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_ready       = (r_state == StIdle);
    assign o_grant_valid = (r_state == StWait);
    assign o_grant       = r_grant;
    assign o_pointer     = r_pointer;

endmodule

// File: tb/tb_islip_grant_arbiter.sv
// Self-checking bench for islip_grant_arbiter: directed vector table, hand-written reset and
// timeout sequences, then randomized traffic against a cycle-level reference model.
module tb_islip_grant_arbiter;

    localparam int N  = 24;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  i_request;
    logic          i_req_valid, i_first_iter, i_accept, i_reject;
    logic          o_ready, o_grant_valid, o_timeout;
    logic [N-1:0]  o_grant;
    logic [4:0]    o_pointer;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_busy;
    int m_ptr, m_g, m_wait;
    bit m_first, m_to;

    typedef struct {
        logic [N-1:0] req;
        logic         v, f, a, r;
        logic [N-1:0] g;
        logic         gv, rdy;
        logic [4:0]   ptr;
    } vec_t;

    vec_t vecs[$];

    islip_grant_arbiter #(
        .N              (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_request     (i_request),
        .i_req_valid   (i_req_valid),
        .i_first_iter  (i_first_iter),
        .i_accept      (i_accept),
        .i_reject      (i_reject),
        .o_ready       (o_ready),
        .o_grant       (o_grant),
        .o_grant_valid (o_grant_valid),
        .o_pointer     (o_pointer),
        .o_timeout     (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [N-1:0] req, logic v, logic f, logic a, logic r,
                                logic [N-1:0] g, logic gv, logic [4:0] ptr);
        vec_t t;
        t.req = req; t.v = v; t.f = f; t.a = a; t.r = r;
        t.g = g; t.gv = gv; t.rdy = ~gv; t.ptr = ptr;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] g, input logic gv,
                              input logic rdy, input logic [4:0] ptr, input logic to);
        chk({tag, ".grant"}, 32'(o_grant), 32'(g));
        chk({tag, ".grant_valid"}, 32'(o_grant_valid), 32'(gv));
        chk({tag, ".ready"}, 32'(o_ready), 32'(rdy));
        chk({tag, ".pointer"}, 32'(o_pointer), 32'(ptr));
        chk({tag, ".timeout"}, 32'(o_timeout), 32'(to));
    endtask

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_g = 0; m_wait = 0; m_first = 0; m_to = 0;
    endtask

    // Arbiter behaviour expressed as cyclic index arithmetic over the request bits.
    task automatic model_step(input logic [N-1:0] req, input logic v, input logic f,
                              input logic a, input logic r);
        m_to = 0;
        if (!m_busy) begin
            if (v && req != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (req[(m_ptr + k) % N]) begin
                        m_g = (m_ptr + k) % N;
                        break;
                    end
                end
                m_busy = 1; m_first = f; m_wait = 0;
            end
        end else if (a) begin
            m_busy = 0;
            if (m_first) m_ptr = (m_g + 1) % N;
        end else if (r) begin
            m_busy = 0;
        end else begin
            m_wait++;
`ifdef ISLIP_GRANT_TIMEOUT_EN
            if (m_wait == TO) begin
                m_busy = 0;
                m_to   = 1;
            end
`endif
        end
    endtask

    task automatic drive(input logic [N-1:0] req, input logic v, input logic f,
                         input logic a, input logic r);
        i_request = req; i_req_valid = v; i_first_iter = f; i_accept = a; i_reject = r;
        model_step(req, v, f, a, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] g;
        g = m_busy ? (N'(1) << m_g) : '0;
        check_outs(tag, g, m_busy, !m_busy, 5'(m_ptr), m_to);
    endtask

    initial begin
        rst_n = 1'b0;
        i_request = '0; i_req_valid = 0; i_first_iter = 0; i_accept = 0; i_reject = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("in_reset", '0, 0, 1, 5'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("after_reset", '0, 0, 1, 5'd0, 0);

        //                req        v  f  a  r  exp_grant  gv ptr
        vecs.push_back(mk(24'h000210, 1, 1, 0, 0, 24'h000010, 1, 5'd0));
        vecs.push_back(mk(24'h000000, 0, 0, 1, 0, 24'h000000, 0, 5'd5));
        vecs.push_back(mk(24'h000210, 1, 1, 0, 0, 24'h000200, 1, 5'd5));
        vecs.push_back(mk(24'h000000, 0, 0, 0, 1, 24'h000000, 0, 5'd5));
        vecs.push_back(mk(24'h000210, 1, 0, 0, 0, 24'h000200, 1, 5'd5));
        vecs.push_back(mk(24'h000000, 0, 0, 1, 0, 24'h000000, 0, 5'd5));
        vecs.push_back(mk(24'h400000, 1, 1, 0, 0, 24'h400000, 1, 5'd5));
        vecs.push_back(mk(24'h000000, 0, 0, 1, 0, 24'h000000, 0, 5'd23));
        vecs.push_back(mk(24'h800001, 1, 1, 0, 0, 24'h800000, 1, 5'd23));
        vecs.push_back(mk(24'h000000, 0, 0, 1, 0, 24'h000000, 0, 5'd0));
        vecs.push_back(mk(24'h800001, 1, 1, 0, 0, 24'h000001, 1, 5'd0));
        vecs.push_back(mk(24'h000000, 0, 0, 1, 0, 24'h000000, 0, 5'd1));
        vecs.push_back(mk(24'h000000, 1, 1, 0, 0, 24'h000000, 0, 5'd1));
        vecs.push_back(mk(24'h000000, 0, 1, 1, 0, 24'h000000, 0, 5'd1));
        vecs.push_back(mk(24'hffffff, 0, 1, 0, 0, 24'h000000, 0, 5'd1));
        vecs.push_back(mk(24'h000080, 1, 1, 0, 0, 24'h000080, 1, 5'd1));
        vecs.push_back(mk(24'hffffff, 1, 0, 0, 0, 24'h000080, 1, 5'd1));
        vecs.push_back(mk(24'h000000, 0, 0, 1, 1, 24'h000000, 0, 5'd8));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].v, vecs[i].f, vecs[i].a, vecs[i].r);
            check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].gv, vecs[i].rdy,
                       vecs[i].ptr, 1'b0);
        end

        // Asynchronous reset in the middle of an outstanding grant
        drive(24'h000008, 1, 1, 0, 0);
        check_outs("pre_async_rst", 24'h000008, 1, 0, 5'd8, 0);
        i_req_valid = 0;
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", '0, 0, 1, 5'd0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ISLIP_GRANT_TIMEOUT_EN
        drive(24'h000004, 1, 1, 0, 0);
        check_outs("to_grant", 24'h000004, 1, 0, 5'd0, 0);
        for (int i = 1; i < TO; i++) begin
            drive('0, 0, 0, 0, 0);
            check_outs($sformatf("to_hold%0d", i), 24'h000004, 1, 0, 5'd0, 0);
        end
        drive('0, 0, 0, 0, 0);
        check_outs("to_expire", '0, 0, 1, 5'd0, 1);
        drive('0, 0, 0, 0, 0);
        check_outs("to_pulse_end", '0, 0, 1, 5'd0, 0);

        drive(24'h000004, 1, 1, 0, 0);
        for (int i = 1; i < TO; i++) begin
            drive('0, 0, 0, 0, 0);
        end
        drive('0, 0, 0, 1, 0);
        check_outs("to_accept_wins", '0, 0, 1, 5'd3, 0);
`endif

        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] req;
            req = N'($urandom());
            if ($urandom_range(0, 2) == 0) req = req & N'($urandom()) & N'($urandom());
            if ($urandom_range(0, 9) == 0) req = '0;
            drive(req, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            check_model($sformatf("rand%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/islip_grant_arbiter.md
# islip_grant_arbiter

Round-robin grant arbiter for one output port of the flattened-priority iSLIP scheduler. It sits directly downstream of the request-evaluation stage and consumes its N-bit per-input request vector. It issues a registered one-hot grant, holds it until the accept stage responds, and advances its round-robin pointer only on an accepted first-iteration grant, as iSLIP requires.

## Interface
- N, 24, number of inputs (request vector width)
- PW, $clog2(N), pointer width (derived, not overridden)
- TIMEOUT_CYCLES, 16, grant-hold limit in cycles (used only with ISLIP_GRANT_TIMEOUT_EN)

- i_clk  input  1  single clock; all state updates on rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_request  input  N  per-input request from request evaluation; bit i = input i requests this output
- i_req_valid  input  1  i_request is valid this cycle (start of an iteration)
- i_first_iter  input  1  this iteration is the first iSLIP iteration; sampled with i_request
- i_accept  input  1  accept stage accepted the outstanding grant
- i_reject  input  1  accept stage rejected the outstanding grant
- o_ready  output  1  arbiter is idle and samples i_request
- o_grant  output  N  one-hot grant, all-zero when no grant is outstanding
- o_grant_valid  output  1  o_grant is outstanding
- o_pointer  output  PW  current round-robin pointer
- o_timeout  output  1  one-cycle pulse when a grant is dropped by timeout

## Operation
- States: IDLE, WAIT (grant outstanding).
- IDLE: o_ready=1. When i_req_valid=1 and i_request!=0, select the first set bit at index >= o_pointer, searching cyclically (index N-1 wraps to 0). Register the one-hot o_grant, latch i_first_iter, and go to WAIT.
- IDLE with i_req_valid=1 and i_request==0: no grant, stay in IDLE, o_grant_valid stays 0.
- WAIT: o_ready=0. o_grant and o_grant_valid are held stable, and i_request/i_req_valid are ignored.
- WAIT with i_accept=1: go to IDLE and clear o_grant. If the latched first_iter=1, the pointer becomes (g+1) mod N, where g is the granted index (g=N-1 gives pointer 0). Otherwise the pointer is unchanged.
- WAIT with i_reject=1 (and i_accept=0): go to IDLE, clear o_grant, pointer unchanged.
- i_accept and i_reject together: accept wins.
- i_accept/i_reject while in IDLE: ignored.
- Reset (at any time, including mid-WAIT) asynchronously forces IDLE:
  - o_pointer=0, o_grant=0, o_grant_valid=0, o_timeout=0, o_ready=1.
  - The outstanding grant is dropped without a pointer update.

## Timing
- Request sampled at edge T, with o_ready=1 and i_req_valid=1. o_grant/o_grant_valid are visible after edge T, so the arbiter has 1-cycle latency.
- Accept/reject sampled at edge A. After edge A: o_grant_valid=0, o_ready=1, and the new o_pointer is visible.
- A new request can therefore be sampled at edge A+1. Minimum iteration period is 2 cycles.
- o_ready is decoded from the state register (no combinational path from inputs).
- o_grant is a register output. The cyclic search is the only deep combinational path (i_request to grant register).

## Configuration
- ISLIP_GRANT_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each cycle in WAIT.
  - When TIMEOUT_CYCLES cycles have elapsed in WAIT with no accept/reject, the arbiter behaves as a reject: IDLE next cycle, pointer unchanged, o_timeout=1 for exactly that one cycle.
  - An accept/reject on the same edge as expiry takes precedence, and o_timeout stays 0.
- ISLIP_GRANT_TIMEOUT_EN undefined: WAIT holds indefinitely, o_timeout is tied to 0, and no counter exists.

## Structure
- Shared package islip_pkg holds:
  - the state enum (IDLE, WAIT);
  - the pointer-width helper function;
  - the default N and TIMEOUT_CYCLES constants, shared with request evaluation and the accept stage.
- Sub-module rr_select: purely combinational; inputs request[N] and pointer[PW]; outputs one-hot grant[N] plus any-bit. Reused by the accept arbiter.

## Test plan
- Reset, N=24: after release, o_pointer=0, o_ready=1, o_grant=0. Request 0x000210 with first_iter=1 -> o_grant=0x000010 next cycle. Accept -> o_pointer=5.
- Pointer=5, request 0x000210 with first_iter=1 -> grant 0x000200. Reject -> pointer stays 5. Same request with first_iter=0, then accept -> pointer stays 5.
- Wrap-around: pointer=23, request 0x800001 -> grant bit 23. Accept with first_iter=1 -> pointer=0. Next request 0x800001 -> grant bit 0.
- Zero request with i_req_valid=1 -> o_grant_valid stays 0 and o_ready stays 1. i_accept pulsed in IDLE -> pointer unchanged.
- Simultaneous i_accept=1 and i_reject=1 on grant bit 7 with first_iter=1 -> pointer=8. Async reset asserted mid-WAIT -> outputs at reset values immediately, pointer=0.
- With ISLIP_GRANT_TIMEOUT_EN and TIMEOUT_CYCLES=4: grant held with no response -> o_timeout pulses one cycle after 4 WAIT cycles, IDLE follows, pointer unchanged. Accept on the expiry edge -> no o_timeout, pointer advances.
